// File: rtl/encoder_scan.sv
// rtl/encoder_scan.sv - multi-hot to binary index scanner, one beat per set bit
module encoder_scan #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_bits,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_bits,
  output logic       out_last,
  output logic       out_zero,
  output logic [3:0] out_count
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state;
  logic [7:0] pending;
  logic [7:0] pending_next;

  function automatic logic [2:0] pick_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (m[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (m[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] m);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, m[i]};
    end
    return cnt;
  endfunction

  // At most one bit set: clearing the lowest set bit leaves nothing.
  function automatic logic is_last(input logic [7:0] m);
    return (m & (m - 8'd1)) == 8'd0;
  endfunction

  assign pending_next = pending & ~(8'd1 << out_bits);

  // Beat fields are precomputed from the mask that the next beat will use,
  // so every output comes straight from a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      out_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_last  <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= SCAN;
            pending   <= in_bits;
            out_count <= popcount(in_bits);
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_bits  <= pick_idx(in_bits);
            out_last  <= is_last(in_bits);
            out_zero  <= (in_bits == 8'd0);
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              pending   <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_bits  <= '0;
              out_last  <= 1'b0;
              out_zero  <= 1'b0;
            end else begin
              pending  <= pending_next;
              out_bits <= pick_idx(pending_next);
              out_last <= is_last(pending_next);
              out_zero <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_scan.sv
// tb/tb_encoder_scan.sv - directed table-driven bench for encoder_scan
module tb_encoder_scan;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_bits;
  logic       out_ready;
  logic       sel_msb;

  logic       l_in_ready, l_out_valid, l_out_last, l_out_zero;
  logic [2:0] l_out_bits;
  logic [3:0] l_out_count;
  logic       m_in_ready, m_out_valid, m_out_last, m_out_zero;
  logic [2:0] m_out_bits;
  logic [3:0] m_out_count;

  logic       o_in_ready, o_out_valid, o_out_last, o_out_zero;
  logic [2:0] o_out_bits;
  logic [3:0] o_out_count;

  int n_checks = 0;
  int n_fail   = 0;

  encoder_scan #(.LSB_FIRST(1'b1)) dut_lsb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits),
    .in_ready(l_in_ready), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_bits(l_out_bits), .out_last(l_out_last), .out_zero(l_out_zero),
    .out_count(l_out_count)
  );

  encoder_scan #(.LSB_FIRST(1'b0)) dut_msb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits),
    .in_ready(m_in_ready), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_bits(m_out_bits), .out_last(m_out_last), .out_zero(m_out_zero),
    .out_count(m_out_count)
  );

  assign o_in_ready  = sel_msb ? m_in_ready  : l_in_ready;
  assign o_out_valid = sel_msb ? m_out_valid : l_out_valid;
  assign o_out_last  = sel_msb ? m_out_last  : l_out_last;
  assign o_out_zero  = sel_msb ? m_out_zero  : l_out_zero;
  assign o_out_bits  = sel_msb ? m_out_bits  : l_out_bits;
  assign o_out_count = sel_msb ? m_out_count : l_out_count;

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]      bits;
    logic            msb;
    int              n;
    logic [7:0][2:0] idx;
    int              cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vector(input logic [7:0] v, input logic msb, input int n,
                            input logic [7:0][2:0] idx, input int cnt);
    int beats;
    sel_msb = msb;
    @(negedge clock);
    check($sformatf("in_ready_idle_%02h", v), o_in_ready, 1);
    in_valid  = 1'b1;
    in_bits   = v;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_bits  = ~v;
    beats    = 0;
    for (int c = 0; c < 12; c++) begin
      if (!o_out_valid) break;
      if (beats < 8) check($sformatf("bits_%02h_b%0d", v, beats), o_out_bits, idx[beats]);
      check($sformatf("last_%02h_b%0d", v, beats), o_out_last, (beats == n - 1) ? 1 : 0);
      check($sformatf("zero_%02h_b%0d", v, beats), o_out_zero, (v == 8'd0) ? 1 : 0);
      check($sformatf("count_%02h_b%0d", v, beats), o_out_count, cnt);
      beats++;
      @(negedge clock);
    end
    check($sformatf("beats_%02h", v), beats, n);
    check($sformatf("valid_after_%02h", v), o_out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int stalled;
    logic [2:0] prev_bits;
    logic       prev_last;
    logic [3:0] prev_count;
    int got[4];
    int ngot;
    int t7;

    reset = 1'b1; in_valid = 1'b0; in_bits = 8'h00; out_ready = 1'b0; sel_msb = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_valid_l", l_out_valid, 0);
    check("rst_bits_l", l_out_bits, 0);
    check("rst_last_l", l_out_last, 0);
    check("rst_zero_l", l_out_zero, 0);
    check("rst_count_l", l_out_count, 0);
    check("rst_valid_m", m_out_valid, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", l_in_ready, 1);
    check("post_rst_valid", l_out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      tbl[i].bits = 8'(1 << i); tbl[i].msb = 1'b0; tbl[i].n = 1; tbl[i].cnt = 1;
      tbl[i].idx = '0; tbl[i].idx[0] = 3'(i);
    end
    tbl[8].bits = 8'hA5; tbl[8].msb = 1'b0; tbl[8].n = 4; tbl[8].cnt = 4; tbl[8].idx = '0;
    tbl[8].idx[0] = 3'd0; tbl[8].idx[1] = 3'd2; tbl[8].idx[2] = 3'd5; tbl[8].idx[3] = 3'd7;
    tbl[9].bits = 8'hA5; tbl[9].msb = 1'b1; tbl[9].n = 4; tbl[9].cnt = 4; tbl[9].idx = '0;
    tbl[9].idx[0] = 3'd7; tbl[9].idx[1] = 3'd5; tbl[9].idx[2] = 3'd2; tbl[9].idx[3] = 3'd0;
    tbl[10].bits = 8'h00; tbl[10].msb = 1'b0; tbl[10].n = 1; tbl[10].cnt = 0; tbl[10].idx = '0;
    tbl[11].bits = 8'h00; tbl[11].msb = 1'b1; tbl[11].n = 1; tbl[11].cnt = 0; tbl[11].idx = '0;
    tbl[12].bits = 8'hFF; tbl[12].msb = 1'b1; tbl[12].n = 8; tbl[12].cnt = 8;
    for (int j = 0; j < 8; j++) tbl[12].idx[j] = 3'(7 - j);
    tbl[13].bits = 8'h48; tbl[13].msb = 1'b1; tbl[13].n = 2; tbl[13].cnt = 2; tbl[13].idx = '0;
    tbl[13].idx[0] = 3'd6; tbl[13].idx[1] = 3'd3;

    for (int i = 0; i < 14; i++)
      run_vector(tbl[i].bits, tbl[i].msb, tbl[i].n, tbl[i].idx, tbl[i].cnt);

    // Backpressure: 0xFF with random out_ready, outputs must hold while stalled.
    sel_msb = 1'b0;
    @(negedge clock);
    in_valid = 1'b1; in_bits = 8'hFF; out_ready = 1'b0;
    @(negedge clock);
    in_valid = 1'b0; in_bits = 8'h00;
    beats = 0; stalled = 0; prev_bits = '0; prev_last = 1'b0; prev_count = '0;
    for (int c = 0; c < 200 && beats < 8; c++) begin
      if (!o_out_valid) begin
        check("bp_valid_early_drop", o_out_valid, 1);
        break;
      end
      check("bp_in_ready", o_in_ready, 0);
      if (stalled != 0) begin
        check("bp_hold_bits", o_out_bits, prev_bits);
        check("bp_hold_last", o_out_last, prev_last);
        check("bp_hold_count", o_out_count, prev_count);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (c > 150) out_ready = 1'b1;
      if (out_ready) begin
        check($sformatf("bp_bits_b%0d", beats), o_out_bits, beats);
        check($sformatf("bp_last_b%0d", beats), o_out_last, (beats == 7) ? 1 : 0);
        check("bp_count", o_out_count, 8);
        beats++;
        stalled = 0;
      end else begin
        stalled = 1;
        prev_bits = o_out_bits; prev_last = o_out_last; prev_count = o_out_count;
      end
      @(negedge clock);
    end
    check("bp_beats", beats, 8);
    check("bp_valid_after", o_out_valid, 0);
    out_ready = 1'b1;

    // Reset after two of four beats of 0x0F.
    @(negedge clock);
    in_valid = 1'b1; in_bits = 8'h0F;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_bits_before_rst", o_out_bits, 2);
    check("mid_valid_before_rst", o_out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", o_out_valid, 0);
    check("mid_rst_bits", o_out_bits, 0);
    check("mid_rst_last", o_out_last, 0);
    check("mid_rst_count", o_out_count, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mid_no_more_beats", o_out_valid, 0);
    check("mid_in_ready", o_in_ready, 1);
    begin
      logic [7:0][2:0] one_idx;
      one_idx = '0; one_idx[0] = 3'd4;
      run_vector(8'h10, 1'b0, 1, one_idx, 1);
    end

    // Back-to-back 0x03 then 0x80 with in_valid held high.
    sel_msb = 1'b0;
    @(negedge clock);
    in_valid = 1'b1; in_bits = 8'h03; out_ready = 1'b1;
    ngot = 0; t7 = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      in_bits = 8'h80;
      if (o_out_valid) begin
        if (ngot < 4) got[ngot] = int'(o_out_bits);
        ngot++;
        if (o_out_bits == 3'd7) begin
          t7 = c;
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("tp_beats", ngot, 3);
    check("tp_beat0", got[0], 0);
    check("tp_beat1", got[1], 1);
    check("tp_beat2", got[2], 7);
    check("tp_beat7_cycle", t7, 3);
    check("tp_valid_after", o_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
